// File: rtl/video_pkg.sv
// Shared video constants: screen placement in the CPU map, screen RAM
// geometry and the screen writer state encoding. Also imported by vga_render.
package video_pkg;

    // Screen region in the CPU byte address space (32x32 pixels, 1 byte each).
    localparam logic [15:0] VIDEO_SCREEN_BASE = 16'h0200;
    localparam int          VIDEO_SCREEN_SIZE = 1024;

    // Screen RAM byte address width.
    localparam int VIDEO_ADDR_W = 11;

    // Screen writer controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } writer_state_e;

    // One queued pixel write: screen RAM address plus palette index.
    typedef struct packed {
        logic [VIDEO_ADDR_W-1:0] addr;
        logic [7:0]              data;
    } pix_wr_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is dropped.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Entry storage: written on an accepted push.
    // NOTE: the storage array has no reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; reset empties the queue.
    // NOTE: non-blocking assignments in clocked blocks so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/screen_writer.sv
// Screen writer: queues CPU pixel writes that hit the screen region and
// replays them into screen RAM, and fills the whole screen with one colour on
// request. Queued writes are drained before a fill; writes arriving during a
// fill are held and written afterwards so they overwrite the fill colour.
module screen_writer
    import video_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] SCREEN_BASE = VIDEO_SCREEN_BASE,
    parameter int          SCREEN_SIZE = VIDEO_SCREEN_SIZE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        clear_req,
    input  logic [7:0]  clear_color,
    output logic        ram_write_en,
    output logic [10:0] ram_waddr,
    output logic [7:0]  ram_din,
    output logic        busy,
    output logic        overflow
);

    localparam int          CW        = $clog2(SCREEN_SIZE);
    localparam logic [16:0] REGION_LO = {1'b0, SCREEN_BASE};
    localparam logic [16:0] REGION_HI = REGION_LO + 17'(SCREEN_SIZE);
    localparam logic [10:0] BASE_LO   = SCREEN_BASE[10:0];
    localparam logic [CW-1:0] FILL_LAST = CW'(SCREEN_SIZE - 1);

    writer_state_e state_q;
    logic          ram_we_q;
    logic [10:0]   ram_waddr_q;
    logic [7:0]    ram_din_q;
    logic          busy_q;
    logic          overflow_q;
    logic [7:0]    color_q;
    logic [CW-1:0] fill_cnt_q;

    logic    in_region;
    logic    push_req;
    logic    fifo_pop;
    logic    fifo_full;
    logic    fifo_empty;
    logic    overflow_set;
    pix_wr_t wr_entry;
    pix_wr_t rd_entry;

    // Region decode, queue handshake and drop detection.
    // NOTE: every signal gets a default first, so no path through this block can infer a latch.
    always_comb begin
        in_region    = 1'b0;
        push_req     = 1'b0;
        fifo_pop     = 1'b0;
        overflow_set = 1'b0;
        wr_entry     = '{addr: cpu_addr[10:0], data: cpu_data};
        if (({1'b0, cpu_addr} >= REGION_LO) && ({1'b0, cpu_addr} < REGION_HI)) begin
            in_region = 1'b1;
        end
        push_req     = cpu_we && in_region && !reset;
        // The fill owns the RAM port, so the queue is frozen while clearing.
        fifo_pop     = (state_q != ST_CLEAR) && !fifo_empty;
        overflow_set = push_req && fifo_full && !fifo_pop;
    end

    sync_fifo #(
        .WIDTH ($bits(pix_wr_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_req),
        .wdata_i (wr_entry),
        .pop_i   (fifo_pop),
        .rdata_o (rd_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Controller FSM with registered RAM-port, busy and overflow outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ram_we_q    <= 1'b0;
            ram_waddr_q <= '0;
            ram_din_q   <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            color_q     <= '0;
            fill_cnt_q  <= '0;
        end else begin
            ram_we_q <= 1'b0;
            // A popped entry goes to the RAM port on the next cycle.
            if (fifo_pop) begin
                ram_we_q    <= 1'b1;
                ram_waddr_q <= rd_entry.addr;
                ram_din_q   <= rd_entry.data;
            end
            case (state_q)
                ST_IDLE: begin
                    if (clear_req) begin
                        color_q    <= clear_color;
                        overflow_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Start the fill only once nothing older is left to write.
                    if (fifo_empty && !push_req) begin
                        fill_cnt_q <= '0;
                        state_q    <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    ram_we_q    <= 1'b1;
                    ram_waddr_q <= BASE_LO + 11'(fill_cnt_q);
                    ram_din_q   <= color_q;
                    fill_cnt_q  <= fill_cnt_q + CW'(1);
                    if (fill_cnt_q == FILL_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
            // A drop in the same cycle as an accepted clear still leaves the flag set.
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign ram_write_en = ram_we_q;
    assign ram_waddr    = ram_waddr_q;
    assign ram_din      = ram_din_q;
    assign busy         = busy_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_screen_writer.sv
// Directed bench for screen_writer: latency, region decode, fills, queue
// ordering across a fill, overflow handling and reset in the middle of a fill.
module tb_screen_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        clear_req;
    logic [7:0]  clear_color;
    logic        ram_write_en;
    logic [10:0] ram_waddr;
    logic [7:0]  ram_din;
    logic        busy;
    logic        overflow;

    int vectors = 0;
    int errors  = 0;
    int wr_seen;

    screen_writer dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_data     (cpu_data),
        .clear_req    (clear_req),
        .clear_color  (clear_color),
        .ram_write_en (ram_write_en),
        .ram_waddr    (ram_waddr),
        .ram_din      (ram_din),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_we(input string tag);
        int n = 0;
        while (!ram_write_en && n < 20) begin
            tick();
            n++;
        end
        check(tag, ram_write_en, 1);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_we   = 1'b1;
        cpu_addr = a;
        cpu_data = d;
        tick();
        cpu_we   = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        cpu_we      = 1'b1;
        cpu_addr    = 16'h0210;
        cpu_data    = 8'hAA;
        clear_req   = 1'b0;
        clear_color = 8'h00;

        // Reset values; the write presented during reset must be dropped.
        tick();
        tick();
        check("rst_we", ram_write_en, 0);
        check("rst_waddr", ram_waddr, 0);
        check("rst_din", ram_din, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", overflow, 0);
        reset  = 1'b0;
        cpu_we = 1'b0;
        tick();
        check("rst_drop_a", ram_write_en, 0);
        tick();
        check("rst_drop_b", ram_write_en, 0);

        // Single write from idle: RAM port two cycles after the CPU write.
        cpu_write(16'h0210, 8'h05);
        check("lat_n1_we", ram_write_en, 0);
        tick();
        check("lat_n2_we", ram_write_en, 1);
        check("lat_n2_addr", ram_waddr, 11'h210);
        check("lat_n2_din", ram_din, 8'h05);
        tick();
        check("lat_n3_we", ram_write_en, 0);

        // Out-of-region writes just below and just above the screen.
        cpu_write(16'h01FF, 8'h12);
        cpu_write(16'h0600, 8'h34);
        check("oor_we_a", ram_write_en, 0);
        tick();
        check("oor_we_b", ram_write_en, 0);
        tick();
        check("oor_we_c", ram_write_en, 0);
        check("oor_ovf", overflow, 0);

        // Last byte of the region is accepted.
        cpu_write(16'h05FF, 8'h33);
        tick();
        check("top_we", ram_write_en, 1);
        check("top_addr", ram_waddr, 11'h5FF);
        check("top_din", ram_din, 8'h33);
        tick();

        // Fill with 0x0E; five writes during the fill overflow a depth-4 queue.
        clear_req   = 1'b1;
        clear_color = 8'h0E;
        tick();
        clear_req   = 1'b0;
        clear_color = 8'hFF;
        check("clr1_busy", busy, 1);
        wait_we("clr1_start");
        for (int i = 0; i < 1024; i++) begin
            check("clr1_we", ram_write_en, 1);
            check("clr1_addr", ram_waddr, 32'h200 + i);
            check("clr1_din", ram_din, 8'h0E);
            if (i == 0) check("clr1_busy_fill", busy, 1);
            if (i == 104) check("clr1_ovf_before", overflow, 0);
            if (i == 105) check("clr1_ovf_after", overflow, 1);
            cpu_we   = (i >= 100 && i <= 104);
            cpu_addr = 16'h0400 + 16'(i - 100);
            cpu_data = 8'h80 + 8'(i - 100);
            tick();
        end
        cpu_we = 1'b0;
        check("clr1_busy_end", busy, 0);
        for (int k = 0; k < 4; k++) begin
            check("q_we", ram_write_en, 1);
            check("q_addr", ram_waddr, 32'h400 + k);
            check("q_din", ram_din, 32'h80 + k);
            tick();
        end
        check("q_done_we", ram_write_en, 0);
        check("q_ovf_sticky", overflow, 1);
        tick();
        check("q_ovf_sticky2", overflow, 1);

        // Clear together with a write: the write lands first, overflow clears.
        clear_req   = 1'b1;
        clear_color = 8'h11;
        cpu_we      = 1'b1;
        cpu_addr    = 16'h0250;
        cpu_data    = 8'h77;
        tick();
        clear_req = 1'b0;
        cpu_we    = 1'b0;
        check("clr2_ovf_cleared", overflow, 0);
        wait_we("clr2_pre");
        check("clr2_pre_addr", ram_waddr, 11'h250);
        check("clr2_pre_din", ram_din, 8'h77);
        tick();
        wait_we("clr2_start");
        // Write during the fill lands after it; a clear_req mid-fill is ignored.
        for (int i = 0; i < 1024; i++) begin
            check("clr2_addr", ram_waddr, 32'h200 + i);
            check("clr2_din", ram_din, 8'h11);
            cpu_we      = (i == 10);
            cpu_addr    = 16'h0300;
            cpu_data    = 8'h01;
            clear_req   = (i == 20);
            clear_color = 8'h55;
            tick();
        end
        cpu_we    = 1'b0;
        clear_req = 1'b0;
        check("late_we", ram_write_en, 1);
        check("late_addr", ram_waddr, 11'h300);
        check("late_din", ram_din, 8'h01);
        tick();
        check("late_done_we", ram_write_en, 0);
        check("late_done_busy", busy, 0);

        // Reset in the middle of a fill, with a write still queued.
        clear_req   = 1'b1;
        clear_color = 8'h3C;
        tick();
        clear_req = 1'b0;
        wait_we("clr3_start");
        for (int i = 0; i < 160; i++) begin
            check("clr3_addr", ram_waddr, 32'h200 + i);
            cpu_we   = (i == 50);
            cpu_addr = 16'h0500;
            cpu_data = 8'h99;
            tick();
        end
        cpu_we = 1'b0;
        check("clr3_at_2a0", ram_waddr, 11'h2A0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_we", ram_write_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_waddr", ram_waddr, 0);
        check("mid_rst_din", ram_din, 0);
        wr_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (ram_write_en) wr_seen++;
            tick();
        end
        check("post_rst_writes", wr_seen, 0);
        check("post_rst_busy", busy, 0);

        // Normal operation resumes after reset.
        cpu_write(16'h0201, 8'h44);
        tick();
        check("resume_we", ram_write_en, 1);
        check("resume_addr", ram_waddr, 11'h201);
        check("resume_din", ram_din, 8'h44);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
